// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the fetch/PC sequencer.
//   state_e   : sequencer FSM states
//   pc_sel_e  : next-PC selector for the pc_next datapath
//   ADDR_W/INSTR_W, DEFAULT_RESET_PC
package pc_seq_pkg;
  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 8;
  localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 8'h00;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    ISSUE  = 3'd2,
    EXEC   = 3'd3,
    HALTED = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    SEL_HOLD = 2'd0,
    SEL_INC  = 2'd1,
    SEL_BR   = 2'd2
  } pc_sel_e;
endpackage

// File: rtl/pc_sequencer_pc_next.sv
// Next-PC datapath: hold, increment or PC-relative branch, all mod 2^ADDR_W.
//   pc        in  current program counter
//   sel       in  hold / inc / branch
//   br_offset in  signed two's-complement offset (carry discarded)
//   pc_nxt    out next program counter
module pc_next
  import pc_seq_pkg::*;
(
  input  logic [ADDR_W-1:0] pc,
  input  pc_sel_e           sel,
  input  logic [ADDR_W-1:0] br_offset,
  output logic [ADDR_W-1:0] pc_nxt
);
  // Plain unsigned add gives the two's-complement result once the carry drops.
  always_comb begin
    pc_nxt = pc;
    case (sel)
      SEL_INC: pc_nxt = pc + 1'b1;
      SEL_BR:  pc_nxt = pc + br_offset;
      default: pc_nxt = pc;
    endcase
  end
endmodule

// File: rtl/pc_sequencer.sv
// Multicycle fetch/PC controller. Owns pc and ir, sequences instruction fetch
// over a req/ack handshake and applies branches reported by execute control.
//   clock, reset(async, active low)
//   start              begin/resume fetching (IDLE/HALTED only)
//   mem_req/mem_addr   fetch request, address = pc
//   mem_ack/mem_rdata  fetch response
//   ir/ir_valid        instruction register, one-cycle new-instruction pulse
//   exec_done/br_taken/br_offset/halt  execute-control feedback (EXEC only)
//   pc, busy, halted, mem_fault (sticky fetch-timeout flag)
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int                TIMEOUT  = 15
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] ir,
  output logic               ir_valid,
  input  logic               exec_done,
  input  logic               br_taken,
  input  logic [ADDR_W-1:0]  br_offset,
  input  logic               halt,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy,
  output logic               halted,
  output logic               mem_fault
);
  // Counter only needs to reach TIMEOUT-1; the terminal check fires on the
  // cycle that would make it TIMEOUT.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  state_e            state;
  logic [CNT_W-1:0]  to_cnt;
  pc_sel_e           sel;
  logic [ADDR_W-1:0] pc_nxt;

  // halt outranks br_taken; ack always wins over timeout.
  always_comb begin
    sel = SEL_HOLD;
    if (state == FETCH && mem_ack)
      sel = SEL_INC;
    else if (state == EXEC && exec_done && !halt && br_taken)
      sel = SEL_BR;
  end

  pc_next u_pc_next (
    .pc        (pc),
    .sel       (sel),
    .br_offset (br_offset),
    .pc_nxt    (pc_nxt)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      ir        <= '0;
      mem_fault <= 1'b0;
      to_cnt    <= '0;
    end else begin
      pc <= pc_nxt;
      case (state)
        IDLE:   if (start) state <= FETCH;
        FETCH: begin
          if (mem_ack) begin
            ir     <= mem_rdata;
            state  <= ISSUE;
            to_cnt <= '0;
          end else if (TIMEOUT != 0 && to_cnt == TO_LAST) begin
            mem_fault <= 1'b1;
            state     <= HALTED;
            to_cnt    <= '0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ISSUE:  state <= EXEC;
        EXEC:   if (exec_done) state <= halt ? HALTED : FETCH;
        HALTED: if (start) state <= FETCH;
        default: state <= IDLE;
      endcase
    end
  end

  // Moore decode straight from the state register.
  assign mem_req  = (state == FETCH);
  assign mem_addr = pc;
  assign ir_valid = (state == ISSUE);
  assign busy     = (state == FETCH) || (state == ISSUE) || (state == EXEC);
  assign halted   = (state == HALTED);
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench: stimulus tasks push the expected {ir, pc} for each fetch into
// a queue; an independent monitor pops and compares on every ir_valid pulse.
module tb_pc_sequencer;
  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_ack = 1'b0;
  logic [7:0] mem_rdata = 8'h00;
  logic [7:0] ir;
  logic       ir_valid;
  logic       exec_done = 1'b0;
  logic       br_taken = 1'b0;
  logic [7:0] br_offset = 8'h00;
  logic       halt = 1'b0;
  logic [7:0] pc;
  logic       busy, halted, mem_fault;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];

  pc_sequencer #(.RESET_PC(8'h00), .TIMEOUT(15)) dut (
    .clock(clock), .reset(reset), .start(start),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .ir(ir), .ir_valid(ir_valid),
    .exec_done(exec_done), .br_taken(br_taken), .br_offset(br_offset),
    .halt(halt), .pc(pc), .busy(busy), .halted(halted), .mem_fault(mem_fault)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: every ir_valid pulse must match the oldest expected fetch.
  always @(negedge clock) begin
    if (reset && ir_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL issue_unexpected: got ir=%0h pc=%0h want none", ir, pc);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        chk("issue_ir", {24'h0, ir}, {24'h0, e[15:8]});
        chk("issue_pc", {24'h0, pc}, {24'h0, e[7:0]});
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Serve one fetch: wait for mem_req, check address, ack after wait_n cycles.
  task automatic do_fetch(input logic [7:0] addr, input logic [7:0] data, input int wait_n);
    int n = 0;
    while (!mem_req && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!mem_req) begin
      total++;
      bad++;
      $display("FAIL fetch_wait: got no mem_req want mem_req at %0h", addr);
    end else begin
      chk("fetch_addr", {24'h0, mem_addr}, {24'h0, addr});
      repeat (wait_n) @(negedge clock);
      mem_ack   = 1'b1;
      mem_rdata = data;
      exp_q.push_back({data, addr + 8'h01});
      @(negedge clock);
      mem_ack   = 1'b0;
      mem_rdata = 8'h00;
    end
  endtask

  // Wait for EXEC, present one exec_done with the given controls, check pc.
  task automatic do_exec(input logic br, input logic [7:0] off, input logic hlt,
                         input logic [7:0] exp_pc, input string name);
    int n = 0;
    while (!(busy && !mem_req && !ir_valid) && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!(busy && !mem_req && !ir_valid)) begin
      total++;
      bad++;
      $display("FAIL exec_wait: got no EXEC want EXEC for %s", name);
    end else begin
      exec_done = 1'b1;
      br_taken  = br;
      br_offset = off;
      halt      = hlt;
      @(negedge clock);
      exec_done = 1'b0;
      br_taken  = 1'b0;
      halt      = 1'b0;
      chk(name, {24'h0, pc}, {24'h0, exp_pc});
    end
  endtask

  initial begin
    int cyc;
    // Reset state
    repeat (2) @(negedge clock);
    chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
    chk("rst_pc", {24'h0, pc}, 32'h00);
    chk("rst_mem_addr", {24'h0, mem_addr}, 32'h00);
    chk("rst_ir", {24'h0, ir}, 32'h00);
    chk("rst_flags", {28'h0, ir_valid, busy, halted, mem_fault}, 32'h0);
    reset = 1'b1;
    @(negedge clock);
    chk("idle_no_start", {31'h0, busy}, 32'h0);

    // First fetch, ack in first FETCH cycle
    pulse_start();
    do_fetch(8'h00, 8'hA5, 0);
    do_exec(1'b1, 8'hFE, 1'b0, 8'hFF, "br_to_ff");

    // Sequential wrap FF -> 00
    do_fetch(8'hFF, 8'h3C, 2);
    do_exec(1'b0, 8'h55, 1'b0, 8'h00, "seq_wrap");

    // Negative branch 10 + F0 -> 00
    do_fetch(8'h00, 8'h11, 0);
    do_exec(1'b1, 8'h0E, 1'b0, 8'h0F, "br_to_0f");
    do_fetch(8'h0F, 8'h22, 1);
    do_exec(1'b1, 8'hF0, 1'b0, 8'h00, "br_neg");

    // 81 + 7F wraps to 00
    do_fetch(8'h00, 8'h33, 0);
    do_exec(1'b1, 8'h7F, 1'b0, 8'h80, "br_to_80");
    do_fetch(8'h80, 8'h44, 0);
    do_exec(1'b1, 8'h7F, 1'b0, 8'h00, "br_wrap");

    // halt beats br_taken
    do_fetch(8'h00, 8'h55, 0);
    do_exec(1'b1, 8'h10, 1'b1, 8'h01, "halt_pc");
    chk("halt_state", {30'h0, halted, busy}, 32'h2);
    repeat (2) @(negedge clock);
    chk("halt_stays", {31'h0, halted}, 32'h1);
    pulse_start();
    do_fetch(8'h01, 8'h66, 0);
    do_exec(1'b0, 8'h00, 1'b0, 8'h02, "resume_seq");

    // Timeout: 15 FETCH cycles without ack
    cyc = 0;
    while (mem_req && cyc < 40) begin
      cyc++;
      @(negedge clock);
    end
    chk("timeout_cycles", cyc, 32'd15);
    chk("timeout_fault", {30'h0, mem_fault, halted}, 32'h3);
    chk("timeout_pc", {24'h0, pc}, 32'h02);

    // Ack on the 15th cycle wins; fault stays sticky
    pulse_start();
    do_fetch(8'h02, 8'h77, 14);
    chk("ack15_no_halt", {31'h0, halted}, 32'h0);
    do_exec(1'b0, 8'h00, 1'b0, 8'h03, "ack15_seq");
    chk("fault_sticky", {31'h0, mem_fault}, 32'h1);

    // Reset mid-FETCH
    repeat (3) @(negedge clock);
    chk("pre_rst_req", {31'h0, mem_req}, 32'h1);
    reset = 1'b0;
    #1;
    chk("async_rst_req", {31'h0, mem_req}, 32'h0);
    chk("async_rst_pc", {24'h0, mem_addr, pc}, 32'h0000);
    chk("async_rst_flags", {29'h0, busy, halted, mem_fault}, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    mem_ack = 1'b1;
    mem_rdata = 8'hEE;
    repeat (3) @(negedge clock);
    mem_ack = 1'b0;
    chk("late_ack_ir", {24'h0, ir}, 32'h00);
    chk("late_ack_state", {24'h0, pc, 6'h0, busy, halted}, 32'h0);

    repeat (2) @(negedge clock);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Multicycle fetch/PC controller for the 8-bit processor.
- Owns the program counter and the instruction register.
- Sequences memory fetch through a req/ack handshake, advances the PC by +1 mod 256, and applies PC-relative branches reported by the execute control.
- Sits between instruction memory and the main control FSM; the PC incrementer and branch adder are the resources it sequences.

Parameters:
RESET_PC, 8'h00, PC value loaded on reset.
TIMEOUT, 15, max cycles to wait for mem_ack in FETCH; 0 disables the timeout.

Ports:
clock  in  1  system clock; all state updates on the rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  begin or resume fetching (level, sampled in IDLE/HALTED)
mem_req  out  1  fetch request to instruction memory
mem_addr  out  8  fetch address (= pc while mem_req)
mem_ack  in  1  memory has valid data on mem_rdata this cycle
mem_rdata  in  8  instruction byte from memory
ir  out  8  instruction register
ir_valid  out  1  one-cycle pulse: ir holds a new instruction
exec_done  in  1  control FSM finished executing current instruction
br_taken  in  1  branch taken; qualified by exec_done
br_offset  in  8  signed two's-complement branch offset, relative to the already-incremented pc
halt  in  1  stop after current instruction; qualified by exec_done
pc  out  8  current program counter
busy  out  1  high in FETCH/ISSUE/EXEC
halted  out  1  high in HALTED
mem_fault  out  1  sticky; set on fetch timeout

Behaviour:
- States: IDLE, FETCH, ISSUE, EXEC, HALTED.
- Encoding is Moore: mem_req, ir_valid, busy and halted decode from state only.
- Reset (reset=0, asynchronous, any state including mid-fetch):
  - state=IDLE, pc=RESET_PC, ir=8'h00, mem_fault=0, timeout counter=0.
  - All outputs 0 except pc and mem_addr, which equal RESET_PC.
- IDLE: start=1 -> FETCH next cycle; otherwise stay.
- FETCH:
  - mem_req=1; mem_addr=pc, held stable until ack.
  - On mem_ack: ir<=mem_rdata, pc<=(pc+1) mod 256, -> ISSUE. Latency from FETCH entry is 1 cycle minimum when ack arrives in the first FETCH cycle.
  - Timeout counter increments each FETCH cycle without ack. If TIMEOUT!=0 and the counter reaches TIMEOUT with no ack: mem_fault<=1, -> HALTED, pc unchanged.
  - Ack in the same cycle the count reaches TIMEOUT: ack wins, no fault.
  - Counter clears on leaving FETCH.
- ISSUE: ir_valid=1 for exactly one cycle -> EXEC.
- EXEC: wait for exec_done.
  - With exec_done, priority is halt > br_taken > sequential:
    - halt=1 -> HALTED, pc unchanged, branch ignored.
    - br_taken=1 -> pc<=(pc+br_offset) mod 256 (8-bit wrap; 8'h80 = -128), -> FETCH.
    - Else -> FETCH with pc unchanged (already incremented).
- HALTED: halted=1. start=1 -> FETCH from current pc; mem_fault is not cleared (only reset clears it).
- Ignored inputs:
  - mem_ack outside FETCH.
  - exec_done, br_taken and halt outside EXEC.
  - start outside IDLE/HALTED.
- Wrap-around: pc=8'hFF fetch -> pc=8'h00. Branch arithmetic discards the carry.
- No X propagation: ir changes only on a FETCH ack.

Decomposition:
- Package pc_seq_pkg:
  - state enum (IDLE=0, FETCH=1, ISSUE=2, EXEC=3, HALTED=4, 3-bit).
  - ADDR_W=8, INSTR_W=8.
  - Constant for the default RESET_PC.
- Sub-module pc_next: combinational. Inputs pc, sel (hold/inc/branch), br_offset; output next pc mod 256. Keeps all PC arithmetic in one place.
- The FSM, IR and timeout counter stay in pc_sequencer.

Test Plan:
- Reset then start=1, memory acks in 1st FETCH cycle with 8'hA5 -> mem_addr=00, ir=A5, ir_valid pulse 1 cycle later, pc=01.
- pc preset via branch to 8'hFF, sequential fetch, exec_done with br_taken=0 -> pc=00, next mem_addr=00.
- pc=8'h10 after fetch, exec_done with br_taken=1, br_offset=8'hF0 -> pc=00. Then br_offset=8'h7F from pc=8'h81 -> pc=00 (wrap).
- exec_done with halt=1 and br_taken=1 simultaneously -> HALTED, pc unchanged. start=1 -> FETCH at that pc.
- TIMEOUT=15, no mem_ack -> mem_fault=1 and HALTED after 15 FETCH cycles. Ack on cycle 15 -> no fault, ISSUE.
- Assert reset low mid-FETCH with mem_req=1 -> immediately mem_req=0, state IDLE, pc=RESET_PC. A late mem_ack after release is ignored.
